dino_motion_ctrl: RTL and testbench
===================================

Name: dino_motion_ctrl

Overview:
Game-state and dinosaur-motion sequencer for the Dino runner.
- Turns jump/squat/crash/restart events into a registered dinosaur Y coordinate, sprite-select bits and a game-state code.
- Sits between the input decoders (keypad, PS2) and the VGA compositing logic.
- Replaces per-frame level-gated jump arithmetic with a single FSM driven by a step tick.

Parameters:
GROUND_Y, 196, dinosaur top-left Y when on the ground (9-bit)
LEG_TICKS, 8, step ticks between leg-sprite toggles while running
P1_STEPS, 10, rise/fall phase-1 step count (speed 6 px/step)
P2_STEPS, 10, phase-2 step count (speed 4 px/step)
P3_STEPS, 12, phase-3 step count (speed 2 px/step)

Ports:
clk  in  1  system clock
clrn  in  1  asynchronous active-low reset
step_clk  in  1  slow divider bit (e.g. clk_div[19]); rising edge = one motion step
jump_req  in  1  single-cycle jump request (already edge-detected upstream)
squat_req  in  1  level; high while squat key is held
crash  in  1  level/pulse from collision detection
restart  in  1  single-cycle restart request
dino_y  out  9  dinosaur top-left Y
leg_sel  out  1  0 = left-leg sprite, 1 = right-leg sprite
squatting  out  1  high in SQUAT
airborne  out  1  high in RISE or FALL
game_state  out  2  0 IDLE, 1 PLAY, 2 OVER
land_pulse  out  1  one-cycle pulse on the landing step

Behaviour:
Clock and reset:
- One clock: clk. Reset is asynchronous, active-low (clrn).
- Reset values: dino_y = GROUND_Y; leg_sel, squatting, airborne, land_pulse = 0; game_state = 0; FSM = IDLE; step counter = 0; leg counter = 0.

Step tick:
- tick = rising edge of step_clk, synchronised with a 2-flop synchroniser plus edge detect. Latency: 3 clk from the step_clk edge.
- All motion updates occur only on tick. Outputs are registered and change in the cycle after tick.

FSM states: IDLE, RUN, RISE, FALL, SQUAT, OVER.
- IDLE: dino_y = GROUND_Y. jump_req or restart -> RUN. crash is ignored.
- RUN:
  - jump_req -> RISE with step_cnt = 0. Takes effect immediately; no tick needed.
  - else squat_req -> SQUAT.
  - jump_req and squat_req in the same cycle: jump wins.
- RISE, on each tick:
  - dino_y -= 6, 4 or 2 according to phase; step_cnt++.
  - Phase 1 covers step_cnt < P1_STEPS; phase 2 the next P2_STEPS; phase 3 the next P3_STEPS.
  - When step_cnt reaches P1+P2+P3 -> FALL, step_cnt = 0.
- FALL: mirror of RISE with speeds 2, 4, 6, adding to dino_y.
  - On the final step: dino_y is forced to GROUND_Y, land_pulse = 1 for one cycle, -> RUN.
- Defaults give 124 px rise, apex Y = 72, 64 ticks per jump.
- In RISE/FALL, jump_req and squat_req are ignored (but see Optional Feature).
- SQUAT: squatting = 1, dino_y = GROUND_Y. squat_req low -> RUN. jump_req -> RISE (jump wins).
- Crash: in RUN, RISE, FALL or SQUAT, crash = 1 -> OVER in the next cycle (highest priority over every other input). dino_y and leg_sel freeze; squatting and airborne clear.
- OVER: only restart leaves it. restart -> RUN with dino_y = GROUND_Y, all counters cleared.
- restart outside OVER/IDLE: ignored.

Leg toggle:
- leg_cnt increments on tick in RUN only.
- At LEG_TICKS-1: leg_sel toggles and leg_cnt -> 0.
- leg_cnt is held in all other states.

game_state: IDLE -> 0; OVER -> 2; all others -> 1.

Arithmetic:
- dino_y is 9-bit unsigned.
- Parameters are checked at elaboration: GROUND_Y must be >= total rise. Wrap-around is therefore unreachable.

Mid-operation reset: clrn low at any point returns the block to reset values, including mid-jump.

Optional Feature:
Macro DINO_JUMP_BUFFER_EN.
- Defined: a jump_req received during the last 4 FALL steps sets a one-entry buffer. On landing the FSM goes directly to RISE instead of RUN, and land_pulse still fires. The buffer is cleared by crash, restart and reset.
- Undefined: jump_req while airborne is dropped.

Decomposition:
- Package dino_pkg: FSM state encoding, game_state codes (GS_IDLE/GS_PLAY/GS_OVER), phase speed constants (6/4/2), step-counter width (6 bits).
- Sub-module dino_tick_gen: step_clk synchroniser and rising-edge pulse generator, with clk/clrn.

Test Plan:
- Reset, then 1 tick: dino_y = 196, game_state = 0, leg_sel = 0. jump_req -> game_state = 1 next cycle, dino_y still 196.
- In RUN, jump_req then 32 ticks: dino_y = 196-60-40-24 = 72. 32 further ticks: dino_y = 196, land_pulse high for exactly 1 cycle, state RUN.
- jump_req and squat_req in the same cycle in RUN -> RISE, squatting = 0. Release jump and hold squat in RUN -> squatting = 1, dino_y = 196.
- crash at RISE tick 15 (dino_y = 116) -> game_state = 2, dino_y stays 116 over 20 ticks. restart -> game_state = 1, dino_y = 196.
- 16 ticks in RUN with LEG_TICKS = 8 -> leg_sel toggles twice, at ticks 8 and 16. No toggles during a full jump.
- With DINO_JUMP_BUFFER_EN: jump_req at FALL step 62 -> at landing, no RUN cycle, airborne stays 1, next tick dino_y = 190. Without the macro -> state RUN, dino_y = 196.

Source files
------------

// File: rtl/dino_pkg.sv
// Shared types and constants for the Dino runner motion sequencer.
package dino_pkg;

  localparam int unsigned STEP_W = 6;
  localparam int unsigned Y_W    = 9;

  localparam logic [Y_W-1:0] SPD_FAST = Y_W'(6);
  localparam logic [Y_W-1:0] SPD_MID  = Y_W'(4);
  localparam logic [Y_W-1:0] SPD_SLOW = Y_W'(2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_RISE,
    ST_FALL,
    ST_SQUAT,
    ST_OVER
  } dino_state_e;

  typedef enum logic [1:0] {
    GS_IDLE = 2'd0,
    GS_PLAY = 2'd1,
    GS_OVER = 2'd2
  } game_state_e;

  // Per-step speed; the fall profile is the rise profile played backwards.
  function automatic logic [Y_W-1:0] phase_speed(input logic [STEP_W-1:0] cnt,
                                                 input logic              falling,
                                                 input int unsigned       p1,
                                                 input int unsigned       p2,
                                                 input int unsigned       p3);
    int unsigned idx;
    idx = falling ? (p1 + p2 + p3 - 32'd1 - 32'(cnt)) : 32'(cnt);
    if (idx < p1)           return SPD_FAST;
    else if (idx < p1 + p2) return SPD_MID;
    else                    return SPD_SLOW;
  endfunction

endpackage

// File: rtl/dino_tick_gen.sv
// Synchronises the slow step clock and emits a one-cycle tick per rising edge.
module dino_tick_gen (
  input  logic clk,
  input  logic clrn,
  input  logic step_clk_i,
  output logic tick_o
);

  logic [2:0] sync_q;
  logic       tick_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sync_q <= 3'b000;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], step_clk_i};
      tick_q <= sync_q[1] & ~sync_q[2];
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/dino_motion_ctrl.sv
// Dino game-state and jump/squat motion sequencer, stepped by a synchronised tick.
// Define DINO_JUMP_BUFFER_EN to buffer a jump pressed during the last 4 fall steps.
module dino_motion_ctrl
  import dino_pkg::*;
#(
  parameter int unsigned GROUND_Y  = 196,
  parameter int unsigned LEG_TICKS = 8,
  parameter int unsigned P1_STEPS  = 10,
  parameter int unsigned P2_STEPS  = 10,
  parameter int unsigned P3_STEPS  = 12
) (
  input  logic           clk,
  input  logic           clrn,
  input  logic           step_clk,
  input  logic           jump_req,
  input  logic           squat_req,
  input  logic           crash,
  input  logic           restart,
  output logic [Y_W-1:0] dino_y,
  output logic           leg_sel,
  output logic           squatting,
  output logic           airborne,
  output logic [1:0]     game_state,
  output logic           land_pulse
);

  localparam int unsigned TOTAL   = P1_STEPS + P2_STEPS + P3_STEPS;
  localparam int unsigned RISE_PX = 6 * P1_STEPS + 4 * P2_STEPS + 2 * P3_STEPS;
  localparam int unsigned LEG_W   = (LEG_TICKS > 1) ? $clog2(LEG_TICKS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(TOTAL - 1);
  localparam logic [LEG_W-1:0]  LEG_LAST  = LEG_W'(LEG_TICKS - 1);
  localparam logic [Y_W-1:0]    GROUND    = Y_W'(GROUND_Y);

  if (GROUND_Y < RISE_PX) begin : g_bad_ground
    $error("GROUND_Y smaller than total jump rise");
  end
  if (TOTAL > (1 << STEP_W) || TOTAL < 4) begin : g_bad_steps
    $error("jump step count does not fit the step counter");
  end

  logic tick;

  dino_tick_gen u_tick (
    .clk       (clk),
    .clrn      (clrn),
    .step_clk_i(step_clk),
    .tick_o    (tick)
  );

  dino_state_e       state_q, state_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [LEG_W-1:0]  leg_cnt_q, leg_cnt_d;
  logic              leg_sel_q, leg_sel_d;
  logic              squat_q, squat_d;
  logic              air_q, air_d;
  logic [1:0]        gs_q, gs_d;
  logic              land_q, land_d;
`ifdef DINO_JUMP_BUFFER_EN
  localparam logic [STEP_W-1:0] BUF_FROM = STEP_W'(TOTAL - 4);
  logic              jbuf_q, jbuf_d;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    step_d    = step_q;
    leg_cnt_d = leg_cnt_q;
    leg_sel_d = leg_sel_q;
    land_d    = 1'b0;
`ifdef DINO_JUMP_BUFFER_EN
    jbuf_d    = jbuf_q;
`endif
    if (crash && (state_q inside {ST_RUN, ST_RISE, ST_FALL, ST_SQUAT})) begin
      state_d = ST_OVER;
`ifdef DINO_JUMP_BUFFER_EN
      jbuf_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          y_d = GROUND;
          if (jump_req || restart) begin
            state_d   = ST_RUN;
            step_d    = '0;
            leg_cnt_d = '0;
          end
        end
        ST_RUN: begin
          if (jump_req) begin
            state_d = ST_RISE;
            step_d  = '0;
          end else if (squat_req) begin
            state_d = ST_SQUAT;
          end else if (tick) begin
            if (leg_cnt_q == LEG_LAST) begin
              leg_sel_d = ~leg_sel_q;
              leg_cnt_d = '0;
            end else begin
              leg_cnt_d = leg_cnt_q + LEG_W'(1);
            end
          end
        end
        ST_RISE: begin
          if (tick) begin
            y_d = y_q - phase_speed(step_q, 1'b0, P1_STEPS, P2_STEPS, P3_STEPS);
            if (step_q == LAST_STEP) begin
              state_d = ST_FALL;
              step_d  = '0;
            end else begin
              step_d = step_q + STEP_W'(1);
            end
          end
        end
        ST_FALL: begin
`ifdef DINO_JUMP_BUFFER_EN
          if (jump_req && step_q >= BUF_FROM) jbuf_d = 1'b1;
`endif
          if (tick) begin
            if (step_q == LAST_STEP) begin
              y_d     = GROUND;
              land_d  = 1'b1;
              step_d  = '0;
              state_d = ST_RUN;
`ifdef DINO_JUMP_BUFFER_EN
              if (jbuf_d) begin
                state_d = ST_RISE;
                jbuf_d  = 1'b0;
              end
`endif
            end else begin
              y_d    = y_q + phase_speed(step_q, 1'b1, P1_STEPS, P2_STEPS, P3_STEPS);
              step_d = step_q + STEP_W'(1);
            end
          end
        end
        ST_SQUAT: begin
          y_d = GROUND;
          if (jump_req) begin
            state_d = ST_RISE;
            step_d  = '0;
          end else if (!squat_req) begin
            state_d = ST_RUN;
          end
        end
        ST_OVER: begin
          if (restart) begin
            state_d   = ST_RUN;
            y_d       = GROUND;
            step_d    = '0;
            leg_cnt_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
`ifdef DINO_JUMP_BUFFER_EN
    if (restart) jbuf_d = 1'b0;
`endif
    squat_d = (state_d == ST_SQUAT);
    air_d   = (state_d == ST_RISE) || (state_d == ST_FALL);
    if (state_d == ST_IDLE)      gs_d = GS_IDLE;
    else if (state_d == ST_OVER) gs_d = GS_OVER;
    else                         gs_d = GS_PLAY;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= ST_IDLE;
      y_q       <= GROUND;
      step_q    <= '0;
      leg_cnt_q <= '0;
      leg_sel_q <= 1'b0;
      squat_q   <= 1'b0;
      air_q     <= 1'b0;
      gs_q      <= GS_IDLE;
      land_q    <= 1'b0;
`ifdef DINO_JUMP_BUFFER_EN
      jbuf_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      step_q    <= step_d;
      leg_cnt_q <= leg_cnt_d;
      leg_sel_q <= leg_sel_d;
      squat_q   <= squat_d;
      air_q     <= air_d;
      gs_q      <= gs_d;
      land_q    <= land_d;
`ifdef DINO_JUMP_BUFFER_EN
      jbuf_q    <= jbuf_d;
`endif
    end
  end

  assign dino_y     = y_q;
  assign leg_sel    = leg_sel_q;
  assign squatting  = squat_q;
  assign airborne   = air_q;
  assign game_state = gs_q;
  assign land_pulse = land_q;

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Self-checking bench for dino_motion_ctrl against a jump-profile reference model.
module tb_dino_motion_ctrl;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       step_clk = 1'b0;
  logic       jump_req = 1'b0;
  logic       squat_req = 1'b0;
  logic       crash = 1'b0;
  logic       restart = 1'b0;
  logic [8:0] dino_y;
  logic       leg_sel;
  logic       squatting;
  logic       airborne;
  logic [1:0] game_state;
  logic       land_pulse;

  int checks = 0;
  int errors = 0;
  int land_cnt = 0;
  int ground_cyc = 0;

  dino_motion_ctrl dut (
    .clk       (clk),
    .clrn      (clrn),
    .step_clk  (step_clk),
    .jump_req  (jump_req),
    .squat_req (squat_req),
    .crash     (crash),
    .restart   (restart),
    .dino_y    (dino_y),
    .leg_sel   (leg_sel),
    .squatting (squatting),
    .airborne  (airborne),
    .game_state(game_state),
    .land_pulse(land_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (land_pulse) land_cnt++;
    if (!airborne && game_state == 2'd1) ground_cyc++;
  end

  // Reference: speed of rise step i; the fall replays the rise backwards.
  function automatic int rise_spd(input int i);
    return (i < 10) ? 6 : (i < 20) ? 4 : 2;
  endfunction

  // Y after k ticks since take-off (k in 0..64).
  function automatic int model_y(input int k);
    int h;
    h = 0;
    for (int i = 0; i < k; i++) h += (i < 32) ? rise_spd(i) : -rise_spd(63 - i);
    return 196 - h;
  endfunction

  task automatic tick();
    step_clk = 1'b1;
    repeat (6) @(negedge clk);
    step_clk = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_jump();
    jump_req = 1'b1;
    @(negedge clk);
    jump_req = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (dino_y !== 9'd196) begin errors++; $display("FAIL reset_y: got %0d expected 196", dino_y); end
    checks++; if (game_state !== 2'd0) begin errors++; $display("FAIL reset_gs: got %0d expected 0", game_state); end
    clrn = 1'b1;
    tick();
    checks++; if (dino_y !== 9'd196) begin errors++; $display("FAIL idle_y: got %0d expected 196", dino_y); end
    checks++; if (game_state !== 2'd0) begin errors++; $display("FAIL idle_gs: got %0d expected 0", game_state); end
    checks++; if (leg_sel !== 1'b0) begin errors++; $display("FAIL idle_leg: got %0d expected 0", leg_sel); end
    checks++; if ({airborne, squatting, land_pulse} !== 3'b000) begin errors++; $display("FAIL idle_flags: got %b expected 000", {airborne, squatting, land_pulse}); end
    crash = 1'b1; @(negedge clk); crash = 1'b0;
    checks++; if (game_state !== 2'd0) begin errors++; $display("FAIL idle_crash_ignored: got %0d expected 0", game_state); end
    pulse_jump();
    checks++; if (game_state !== 2'd1) begin errors++; $display("FAIL start_gs: got %0d expected 1", game_state); end
    checks++; if (dino_y !== 9'd196) begin errors++; $display("FAIL start_y: got %0d expected 196", dino_y); end
  endtask

  task automatic test_leg_toggle();
    for (int t = 1; t <= 16; t++) begin
      tick();
      checks++;
      if (leg_sel !== 1'((t / 8) % 2)) begin
        errors++; $display("FAIL leg_tick%0d: got %0d expected %0d", t, leg_sel, (t / 8) % 2);
      end
    end
  endtask

  task automatic test_jump_arc();
    int l0;
    l0 = land_cnt;
    pulse_jump();
    checks++; if (airborne !== 1'b1 || dino_y !== 9'd196) begin errors++; $display("FAIL takeoff: got air=%0d y=%0d expected air=1 y=196", airborne, dino_y); end
    for (int k = 1; k <= 64; k++) begin
      tick();
      checks++;
      if (dino_y !== 9'(model_y(k))) begin errors++; $display("FAIL arc_y%0d: got %0d expected %0d", k, dino_y, model_y(k)); end
    end
    checks++; if (land_cnt - l0 != 1) begin errors++; $display("FAIL land_pulse_count: got %0d expected 1", land_cnt - l0); end
    checks++; if (airborne !== 1'b0 || game_state !== 2'd1) begin errors++; $display("FAIL landed_state: got air=%0d gs=%0d expected air=0 gs=1", airborne, game_state); end
    checks++; if (leg_sel !== 1'b0) begin errors++; $display("FAIL leg_during_jump: got %0d expected 0", leg_sel); end
    repeat (7) tick();
    checks++; if (leg_sel !== 1'b0) begin errors++; $display("FAIL leg_hold23: got %0d expected 0", leg_sel); end
    tick();
    checks++; if (leg_sel !== 1'b1) begin errors++; $display("FAIL leg_tick24: got %0d expected 1", leg_sel); end
  endtask

  task automatic test_jump_squat_priority();
    jump_req = 1'b1; squat_req = 1'b1;
    @(negedge clk);
    jump_req = 1'b0;
    checks++; if (airborne !== 1'b1 || squatting !== 1'b0) begin errors++; $display("FAIL jump_wins: got air=%0d sq=%0d expected air=1 sq=0", airborne, squatting); end
    for (int k = 1; k <= 64; k++) tick();
    checks++; if (squatting !== 1'b1 || dino_y !== 9'd196 || airborne !== 1'b0) begin errors++; $display("FAIL squat_after_land: got sq=%0d y=%0d air=%0d expected 1 196 0", squatting, dino_y, airborne); end
    checks++; if (game_state !== 2'd1) begin errors++; $display("FAIL squat_gs: got %0d expected 1", game_state); end
    squat_req = 1'b0; @(negedge clk);
    checks++; if (squatting !== 1'b0) begin errors++; $display("FAIL squat_release: got %0d expected 0", squatting); end
    squat_req = 1'b1; @(negedge clk);
    checks++; if (squatting !== 1'b1) begin errors++; $display("FAIL squat_enter: got %0d expected 1", squatting); end
    pulse_jump();
    squat_req = 1'b0;
    checks++; if (airborne !== 1'b1 || squatting !== 1'b0) begin errors++; $display("FAIL jump_from_squat: got air=%0d sq=%0d expected 1 0", airborne, squatting); end
    for (int k = 1; k <= 64; k++) tick();
    checks++; if (airborne !== 1'b0 || dino_y !== 9'd196) begin errors++; $display("FAIL squat_jump_land: got air=%0d y=%0d expected 0 196", airborne, dino_y); end
  endtask

  task automatic test_crash_restart();
    pulse_jump();
    repeat (15) tick();
    checks++; if (dino_y !== 9'd116) begin errors++; $display("FAIL rise15_y: got %0d expected 116", dino_y); end
    crash = 1'b1; @(negedge clk); crash = 1'b0;
    checks++; if (game_state !== 2'd2 || airborne !== 1'b0 || squatting !== 1'b0) begin errors++; $display("FAIL crash_state: got gs=%0d air=%0d sq=%0d expected 2 0 0", game_state, airborne, squatting); end
    repeat (20) tick();
    checks++; if (dino_y !== 9'd116 || game_state !== 2'd2) begin errors++; $display("FAIL over_frozen: got y=%0d gs=%0d expected 116 2", dino_y, game_state); end
    pulse_jump();
    checks++; if (game_state !== 2'd2) begin errors++; $display("FAIL over_ignores_jump: got %0d expected 2", game_state); end
    restart = 1'b1; @(negedge clk); restart = 1'b0;
    checks++; if (game_state !== 2'd1 || dino_y !== 9'd196 || airborne !== 1'b0) begin errors++; $display("FAIL restart: got gs=%0d y=%0d air=%0d expected 1 196 0", game_state, dino_y, airborne); end
  endtask

  task automatic test_random_crash();
    int k;
    int extra;
    for (int it = 0; it < 6; it++) begin
      k = int'($urandom_range(63, 1));
      extra = int'($urandom_range(3, 1));
      pulse_jump();
      for (int t = 1; t <= k; t++) begin
        tick();
        checks++;
        if (dino_y !== 9'(model_y(t))) begin errors++; $display("FAIL rnd%0d_y%0d: got %0d expected %0d", it, t, dino_y, model_y(t)); end
      end
      crash = 1'b1; @(negedge clk); crash = 1'b0;
      repeat (extra) tick();
      checks++;
      if (game_state !== 2'd2 || dino_y !== 9'(model_y(k))) begin errors++; $display("FAIL rnd%0d_frozen: got gs=%0d y=%0d expected 2 %0d", it, game_state, dino_y, model_y(k)); end
      restart = 1'b1; @(negedge clk); restart = 1'b0;
      checks++;
      if (game_state !== 2'd1 || dino_y !== 9'd196) begin errors++; $display("FAIL rnd%0d_restart: got gs=%0d y=%0d expected 1 196", it, game_state, dino_y); end
    end
  endtask

  task automatic test_jump_buffer();
    int l0;
    int g0;
    pulse_jump();
    repeat (62) tick();
    checks++; if (dino_y !== 9'(model_y(62))) begin errors++; $display("FAIL buf_y62: got %0d expected %0d", dino_y, model_y(62)); end
    pulse_jump();
    tick();
    l0 = land_cnt;
    g0 = ground_cyc;
    tick();
    checks++; if (land_cnt - l0 != 1 || dino_y !== 9'd196) begin errors++; $display("FAIL buf_landing: got pulses=%0d y=%0d expected 1 196", land_cnt - l0, dino_y); end
`ifdef DINO_JUMP_BUFFER_EN
    checks++; if (airborne !== 1'b1 || ground_cyc - g0 != 0) begin errors++; $display("FAIL buf_rejump: got air=%0d ground_cycles=%0d expected 1 0", airborne, ground_cyc - g0); end
    tick();
    checks++; if (dino_y !== 9'd190) begin errors++; $display("FAIL buf_first_step: got %0d expected 190", dino_y); end
    repeat (63) tick();
    checks++; if (airborne !== 1'b0 || dino_y !== 9'd196) begin errors++; $display("FAIL buf_second_land: got air=%0d y=%0d expected 0 196", airborne, dino_y); end
`else
    checks++; if (airborne !== 1'b0 || ground_cyc - g0 == 0) begin errors++; $display("FAIL nobuf_run: got air=%0d ground_cycles=%0d expected 0 nonzero", airborne, ground_cyc - g0); end
    tick();
    checks++; if (dino_y !== 9'd196 || airborne !== 1'b0) begin errors++; $display("FAIL nobuf_stays: got y=%0d air=%0d expected 196 0", dino_y, airborne); end
`endif
  endtask

  task automatic test_midjump_reset();
    pulse_jump();
    repeat (20) tick();
    checks++; if (dino_y !== 9'(model_y(20))) begin errors++; $display("FAIL pre_reset_y: got %0d expected %0d", dino_y, model_y(20)); end
    clrn = 1'b0;
    @(negedge clk);
    checks++; if (dino_y !== 9'd196 || game_state !== 2'd0 || airborne !== 1'b0 || leg_sel !== 1'b0) begin errors++; $display("FAIL midjump_reset: got y=%0d gs=%0d air=%0d leg=%0d expected 196 0 0 0", dino_y, game_state, airborne, leg_sel); end
    clrn = 1'b1;
    tick();
    checks++; if (dino_y !== 9'd196 || game_state !== 2'd0) begin errors++; $display("FAIL post_reset_idle: got y=%0d gs=%0d expected 196 0", dino_y, game_state); end
  endtask

  initial begin
    test_reset();
    test_leg_toggle();
    test_jump_arc();
    test_jump_squat_priority();
    test_crash_restart();
    test_random_crash();
    test_jump_buffer();
    test_midjump_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
